// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared definitions for the serial adder/subtractor:
//   MODE_ADD / MODE_SUB  - encoding of the mode input
//   stateT               - controller states
//   cntWidth()           - width of the chunk counter for K chunks (minimum 1)
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } stateT;

    function automatic int cntWidth(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational N-bit chunk adder/subtractor built from a ripple of
// full-adder / full-subtractor cells.
//   a, b  : chunk operands
//   cin   : carry-in (add) or borrow-in (subtract)
//   mode  : MODE_ADD or MODE_SUB
//   y     : chunk sum or difference
//   cout  : carry-out (add) or borrow-out (subtract)
// -----------------------------------------------------------------------------
module addsub_slice
    import serial_addsub_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         mode,
    output logic [N-1:0] y,
    output logic         cout
);

    logic [N:0] chain;

    always_comb begin
        chain    = '0;
        y        = '0;
        chain[0] = cin;
        for (int i = 0; i < N; i++) begin
            y[i] = a[i] ^ b[i] ^ chain[i];
            if (mode == MODE_SUB) begin
                // Borrow when a < b, or when a == b and a borrow is pending.
                chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
            end else begin
                chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
            end
        end
        cout = chain[N];
    end

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor processing BITS_PER_CYCLE bits per clock,
// LSB chunk first, through a carry/borrow register.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request strobe, accepted in IDLE or FIN
//   mode          : 0 = A+B, 1 = A-B (latched with operands)
//   a, b          : WIDTH-bit unsigned operands
//   busy          : high while chunks are being processed
//   done          : one-cycle pulse when result/carry_borrow are updated
//   result        : sum/difference modulo 2^WIDTH, held until next done
//   carry_borrow  : carry-out (add) or borrow-out (subtract)
// -----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow
);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : gBadParams
            $fatal(1, "serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cntWidth(K);
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(K - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({BITS_PER_CYCLE{1'b1}});

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0]          opA;
    logic [WIDTH-1:0]          opB;
    logic                      modeReg;
    logic [CW-1:0]             chunkCnt;
    logic                      carryReg;
    logic [WIDTH-1:0]          work;

    logic [BITS_PER_CYCLE-1:0] chunkA;
    logic [BITS_PER_CYCLE-1:0] chunkB;
    logic [BITS_PER_CYCLE-1:0] sliceY;
    logic                      sliceCout;
    logic [WIDTH-1:0]          workNext;
    logic                      accept;
    logic                      lastChunk;
    int                        shiftAmt;

    // start is only honoured outside RUN; requests during RUN are dropped.
    assign accept    = start && (state != ST_RUN);
    assign lastChunk = (chunkCnt == LAST_CHUNK);

    addsub_slice #(
        .N(BITS_PER_CYCLE)
    ) uSlice (
        .a    (chunkA),
        .b    (chunkB),
        .cin  (carryReg),
        .mode (modeReg),
        .y    (sliceY),
        .cout (sliceCout)
    );

    // Select the current chunk and merge its result into the working word.
    always_comb begin
        shiftAmt = int'(chunkCnt) * BITS_PER_CYCLE;
        chunkA   = BITS_PER_CYCLE'(opA >> shiftAmt);
        chunkB   = BITS_PER_CYCLE'(opB >> shiftAmt);
        workNext = (work & ~(CHUNK_MASK << shiftAmt)) | (WIDTH'(sliceY) << shiftAmt);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (start) nextState = ST_RUN;
            ST_RUN:  if (lastChunk) nextState = ST_FIN;
            ST_FIN:  nextState = start ? ST_RUN : ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_FIN);
    end

    // Datapath: operand latch, chunk processing and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA          <= '0;
            opB          <= '0;
            modeReg      <= MODE_ADD;
            chunkCnt     <= '0;
            carryReg     <= 1'b0;
            work         <= '0;
            result       <= '0;
            carry_borrow <= 1'b0;
        end else if (accept) begin
            opA      <= a;
            opB      <= b;
            modeReg  <= mode;
            chunkCnt <= '0;
            carryReg <= 1'b0;
            work     <= '0;
        end else if (state == ST_RUN) begin
            work     <= workNext;
            carryReg <= sliceCout;
            chunkCnt <= chunkCnt + 1'b1;
            // Outputs update only on the edge that enters FIN.
            if (lastChunk) begin
                result       <= workNext;
                carry_borrow <= sliceCout;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;

    logic       busy1, done1, cb1;
    logic [7:0] res1;
    logic       busy4, done4, cb4;
    logic [7:0] res4;
    logic       busy8, done8, cb8;
    logic [7:0] res8;

    int vectors     = 0;
    int miscompares = 0;
    int sel         = 1;

    logic       obsBusy, obsDone, obsCb;
    logic [7:0] obsRes;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(res1), .carry_borrow(cb1)
    );

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy4), .done(done4), .result(res4), .carry_borrow(cb4)
    );

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy8), .done(done8), .result(res8), .carry_borrow(cb8)
    );

    always_comb begin
        obsBusy = busy1;
        obsDone = done1;
        obsRes  = res1;
        obsCb   = cb1;
        if (sel == 4) begin
            obsBusy = busy4;
            obsDone = done4;
            obsRes  = res4;
            obsCb   = cb4;
        end else if (sel == 8) begin
            obsBusy = busy8;
            obsDone = done8;
            obsRes  = res8;
            obsCb   = cb8;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an operation now; the accepting edge is the next rising edge.
    task automatic runOp(input int bpc, input logic m, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] expR,
                         input logic expC, input string tag);
        int k;
        k     = 8 / bpc;
        sel   = bpc;
        mode  = m;
        a     = av;
        b     = bv;
        start = 1'b1;
        for (int e = 1; e <= k; e++) begin
            step();
            start = 1'b0;
            check({tag, " busy"}, 32'(obsBusy), 32'd1);
            check({tag, " noDone"}, 32'(obsDone), 32'd0);
        end
        step();
        check({tag, " done"}, 32'(obsDone), 32'd1);
        check({tag, " idleBusy"}, 32'(obsBusy), 32'd0);
        check({tag, " result"}, 32'(obsRes), 32'(expR));
        check({tag, " carryBorrow"}, 32'(obsCb), 32'(expC));
        step();
        check({tag, " donePulse"}, 32'(obsDone), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        sel   = 1;
        #12;
        check("rst busy", 32'(busy1), 32'd0);
        check("rst done", 32'(done1), 32'd0);
        check("rst result", 32'(res1), 32'd0);
        check("rst carryBorrow", 32'(cb1), 32'd0);
        rst_n = 1'b1;
        step();

        runOp(1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, "addOverflow");
        runOp(1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, "subUnderflow");
        runOp(1, 1'b1, 8'h07, 8'h05, 8'h02, 1'b0, "subPositive");
        runOp(1, 1'b1, 8'h3C, 8'h3C, 8'h00, 1'b0, "subEqual");

        // start pulsed during RUN with different operands and mode is ignored
        sel   = 1;
        mode  = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignore busy1", 32'(busy1), 32'd1);
        step();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        mode  = 1'b1;
        step();
        start = 1'b0;
        check("ignore busy3", 32'(busy1), 32'd1);
        check("ignore noDone3", 32'(done1), 32'd0);
        for (int e = 4; e <= 8; e++) begin
            step();
            check("ignore busy", 32'(busy1), 32'd1);
        end
        step();
        check("ignore done", 32'(done1), 32'd1);
        check("ignore result", 32'(res1), 32'h46);
        check("ignore carryBorrow", 32'(cb1), 32'd0);
        step();
        check("ignore donePulse", 32'(done1), 32'd0);

        // back-to-back: start held high across FIN
        mode  = 1'b0;
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("b2b first busy", 32'(busy1), 32'd1);
        end
        step();
        check("b2b first done", 32'(done1), 32'd1);
        check("b2b first result", 32'(res1), 32'h30);
        check("b2b first carryBorrow", 32'(cb1), 32'd0);
        mode = 1'b1;
        a    = 8'h01;
        b    = 8'h02;
        step();
        start = 1'b0;
        check("b2b reaccept busy", 32'(busy1), 32'd1);
        check("b2b reaccept noDone", 32'(done1), 32'd0);
        check("b2b held result", 32'(res1), 32'h30);
        for (int e = 11; e <= 17; e++) begin
            step();
            check("b2b second busy", 32'(busy1), 32'd1);
        end
        check("b2b held result late", 32'(res1), 32'h30);
        check("b2b held carryBorrow late", 32'(cb1), 32'd0);
        step();
        check("b2b second done", 32'(done1), 32'd1);
        check("b2b second result", 32'(res1), 32'hFF);
        check("b2b second carryBorrow", 32'(cb1), 32'd1);
        step();
        check("b2b second donePulse", 32'(done1), 32'd0);

        // reset asserted during the 4th RUN cycle
        mode  = 1'b1;
        a     = 8'h55;
        b     = 8'h0F;
        start = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            start = 1'b0;
            check("abort busy", 32'(busy1), 32'd1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("abort async busy", 32'(busy1), 32'd0);
        check("abort async done", 32'(done1), 32'd0);
        check("abort async result", 32'(res1), 32'd0);
        check("abort async carryBorrow", 32'(cb1), 32'd0);
        for (int e = 0; e < 3; e++) begin
            step();
            check("abort held done", 32'(done1), 32'd0);
            check("abort held busy", 32'(busy1), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("abort idle busy", 32'(busy1), 32'd0);
        check("abort idle done", 32'(done1), 32'd0);
        runOp(1, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, "addAfterReset");

        // wider chunks
        runOp(4, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, "bpc4 sub");
        runOp(8, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, "bpc8 sub");
        runOp(4, 1'b0, 8'hF8, 8'h0C, 8'h04, 1'b1, "bpc4 addOverflow");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Multi-bit, multi-cycle adder/subtractor. It is the parametrised successor of the team's single-bit half adder/subtractor. It accepts two WIDTH-bit unsigned operands and a mode on a start strobe. It processes BITS_PER_CYCLE bits per clock, LSB chunk first, through a carry/borrow register, then presents the result with a one-cycle done pulse. It is intended for area-constrained datapaths where a full-width ripple adder is not wanted.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only when not busy.
- mode  in  1  0 = add (A+B), 1 = subtract (A−B); latched with operands.
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when result/carry_borrow become valid.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_borrow  out  1  mode 0: carry-out of A+B. Mode 1: borrow-out (1 iff A < B unsigned).

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: state IDLE, busy=0, done=0, result=0, carry_borrow=0.
  - Operand, mode, chunk-counter and carry registers are cleared.
- K = WIDTH/BITS_PER_CYCLE is the number of compute cycles.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE --start=1--> RUN. Latch a, b, mode. Counter=0. Carry register = 0 in both modes (borrow-in 0 for subtract).
  - RUN: each cycle, process chunk[counter] of a and b with the carry register. Write the chunk result into the working register and update the carry register.
  - RUN, after chunk K−1 --> FIN. Working register goes to result; final carry/borrow goes to carry_borrow.
  - FIN --start=1--> RUN (back-to-back accept, new operands latched).
  - FIN --start=0--> IDLE.
- Latency:
  - An accepted start at edge 0 gives busy=1 after edges 1..K.
  - done=1 after edge K+1. Total K+1 cycles from the start edge to done.
  - BITS_PER_CYCLE=WIDTH gives K=1, so 2 cycles.
- Arithmetic per chunk (n=BITS_PER_CYCLE):
  - Add: {c_out, s} = a_chunk + b_chunk + c_in.
  - Subtract: d = a_chunk − b_chunk − bw_in; bw_out = 1 iff a_chunk < b_chunk + bw_in.
  - Each bit is the full-adder/full-subtractor extension of the half-adder/half-subtractor equations (sum/diff = a^b^cin).
- Output holding: result and carry_borrow change only at the FIN transition. They are held stable otherwise, including through IDLE and a subsequent RUN, until the next FIN.
- start while busy=1 is ignored: no re-latch, no queueing. Changes to a, b or mode during RUN have no effect.
- Reset mid-RUN aborts immediately. No done pulse is issued, outputs go to 0, and the next start is accepted normally after rst_n rises.
- Wrap-around:
  - Add overflow: result = (A+B) mod 2^WIDTH, carry_borrow=1.
  - Subtract underflow: result = (A−B) mod 2^WIDTH (two's complement), carry_borrow=1.
- No overflow flag for signed interpretation in this generation.

Decomposition:
- Package serial_addsub_pkg holds:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1;
  - state enum {ST_IDLE, ST_RUN, ST_FIN};
  - a counter-width helper function (clog2 of K, minimum 1).
- One combinational sub-module, addsub_slice:
  - parameter N;
  - inputs a[N], b[N], cin, mode;
  - outputs y[N], cout.
- Instantiated once with N=BITS_PER_CYCLE. The top holds the FSM, counter, operand registers and carry register.

Test Plan:
- WIDTH=8, BPC=1, mode=0, A=0xFF, B=0x01, start at edge 0 -> busy edges 1–8, done only at edge 9, result=0x00, carry_borrow=1.
- Mode=1, A=0x05, B=0x07 -> result=0xFE, carry_borrow=1. Then mode=1, A=0x07, B=0x05 -> result=0x02, carry_borrow=0. Then A=B=0x3C -> result=0x00, carry_borrow=0.
- Mode=0, A=0x12, B=0x34 accepted. During RUN, pulse start with A=0xFF, B=0xFF -> ignored; done gives result=0x46, carry_borrow=0.
- Back-to-back: start held high across FIN -> second operation accepted on the FIN edge. Its done comes K+1 cycles later, and the first result is held until then.
- rst_n low at the 4th cycle of RUN -> busy/done/result/carry_borrow=0 asynchronously, no done pulse. After release, mode=0, A=0x80, B=0x80 -> result=0x00, carry_borrow=1.
- WIDTH=8, BPC=4, mode=1, A=0x10, B=0x01 -> done 3 cycles after the start edge, result=0x0F, carry_borrow=0. With BPC=8, the same operands give done after 2 cycles.
